// File: rtl/key_loader.sv
// Serial key provisioning unit: shifts in a KEY_BITS-wide key MSB-first and drives it on the lock key bus once armed.
// Define KEY_LOADER_CHECKSUM_EN to add the XOR-byte checksum phase, retry counting, FAULT and LOCKOUT.
module key_loader #(
    parameter int KEY_BITS  = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                key_valid,
    input  logic                key_bit,
    output logic                key_ready,
    output logic [KEY_BITS-1:0] key_out,
    output logic                key_armed,
    output logic                key_fault,
    output logic                key_lockout,
    output logic                busy
);

    localparam int CNT_W = $clog2(KEY_BITS);

    if ((KEY_BITS % 8 != 0) || (MAX_RETRY < 1) || (MAX_RETRY > 15)) begin : g_bad_param
        $error("key_loader: illegal KEY_BITS or MAX_RETRY");
    end

`ifdef KEY_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CHK, S_ARMED, S_FAULT, S_LOCKOUT} state_t;

    function automatic logic [7:0] byte_xor(input logic [KEY_BITS-1:0] k);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < KEY_BITS / 8; i++) begin
            acc = acc ^ k[i*8 +: 8];
        end
        return acc;
    endfunction

    logic [7:0] chk_q, chk_d;
    logic [3:0] retry_q, retry_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ARMED} state_t;
`endif

    state_t              state_q, state_d;
    logic [KEY_BITS-1:0] shift_q, shift_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                xfer_s;

    assign xfer_s = key_valid && key_ready;

    // Status decode from the registered state.
    always_comb begin
        key_ready   = 1'b0;
        key_armed   = 1'b0;
        key_fault   = 1'b0;
        key_lockout = 1'b0;
        case (state_q)
            S_SHIFT:   key_ready = 1'b1;
`ifdef KEY_LOADER_CHECKSUM_EN
            S_CHK:     key_ready = 1'b1;
            S_FAULT:   key_fault = 1'b1;
            S_LOCKOUT: begin
                key_fault   = 1'b1;
                key_lockout = 1'b1;
            end
`endif
            S_ARMED:   key_armed = 1'b1;
            default:   key_ready = 1'b0;
        endcase
    end

    assign busy    = key_ready;
    assign key_out = key_q;

    // Next-state logic: the key bus only changes on entry to or exit from ARMED.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
`ifdef KEY_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
        retry_d = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (xfer_s) begin
                    shift_d = {shift_q[KEY_BITS-2:0], key_bit};
                    if (cnt_q == CNT_W'(KEY_BITS - 1)) begin
                        cnt_d = '0;
`ifdef KEY_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_ARMED;
                        key_d   = {shift_q[KEY_BITS-2:0], key_bit};
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = S_SHIFT;
                end
            end
`ifdef KEY_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer_s) begin
                    chk_d = {chk_q[6:0], key_bit};
                    if (cnt_q == CNT_W'(7)) begin
                        cnt_d = '0;
                        if ({chk_q[6:0], key_bit} == byte_xor(shift_q)) begin
                            state_d = S_ARMED;
                            key_d   = shift_q;
                            retry_d = 4'd0;
                        end else begin
                            retry_d = retry_q + 4'd1;
                            state_d = (retry_d == 4'(MAX_RETRY)) ? S_LOCKOUT : S_FAULT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = S_CHK;
                end
            end
            S_FAULT: begin
                if (start) begin
                    state_d = S_SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_LOCKOUT: state_d = S_LOCKOUT;
`endif
            S_ARMED: begin
                if (start) begin
                    state_d = S_SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                    key_d   = '0;
                end else begin
                    state_d = S_ARMED;
                end
            end
            default: begin
                state_d = S_IDLE;
                key_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
`ifdef KEY_LOADER_CHECKSUM_EN
            chk_q   <= 8'h00;
            retry_q <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
`ifdef KEY_LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
            retry_q <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_key_loader.sv
// Randomized self-checking bench for key_loader with a transaction-level reference model.
module tb_key_loader;

    localparam int KB = 64;
    localparam int MR = 3;
`ifdef KEY_LOADER_CHECKSUM_EN
    localparam int NB = KB + 8;
`else
    localparam int NB = KB;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          key_valid = 1'b0;
    logic          key_bit = 1'b0;
    logic          key_ready;
    logic [KB-1:0] key_out;
    logic          key_armed;
    logic          key_fault;
    logic          key_lockout;
    logic          busy;

    key_loader #(.KEY_BITS(KB), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_bit(key_bit),
        .key_ready(key_ready), .key_out(key_out), .key_armed(key_armed),
        .key_fault(key_fault), .key_lockout(key_lockout), .busy(busy)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [KB-1:0] exp_key;
    logic          exp_armed, exp_fault, exp_lock;
    int            exp_retry;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic exp_busy);
        check({tag, ".key_out"}, key_out, exp_key);
        check({tag, ".armed"}, key_armed, exp_armed);
        check({tag, ".fault"}, key_fault, exp_fault);
        check({tag, ".lockout"}, key_lockout, exp_lock);
        check({tag, ".busy"}, busy, exp_busy);
        check({tag, ".ready"}, key_ready, exp_busy);
    endtask

    function automatic logic [7:0] ref_sum(input logic [KB-1:0] k);
        logic [7:0] s;
        s = 8'h00;
        for (int b = 0; b < KB / 8; b++) s = s ^ k[b*8 +: 8];
        return s;
    endfunction

    task automatic model_reset();
        exp_key = '0; exp_armed = 1'b0; exp_fault = 1'b0; exp_lock = 1'b0; exp_retry = 0;
    endtask

    // Outcome of one complete load, from the provisioning rules.
    task automatic model_load(input logic [KB-1:0] key, input logic [7:0] chk);
`ifdef KEY_LOADER_CHECKSUM_EN
        if (chk == ref_sum(key)) begin
            exp_key = key; exp_armed = 1'b1; exp_fault = 1'b0; exp_retry = 0;
        end else begin
            exp_retry = exp_retry + 1;
            exp_key = '0; exp_armed = 1'b0; exp_fault = 1'b1;
            exp_lock = (exp_retry == MR);
        end
`else
        exp_key = key; exp_armed = 1'b1;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; key_valid = 1'b0; start = 1'b0;
        step(); step();
        rst = 1'b0;
        model_reset();
    endtask

    // mode 0: back-to-back, 1: one idle cycle before each bit, 2: random gaps with stray starts.
    task automatic run_load(input logic [KB-1:0] key, input logic [7:0] chk, input int mode);
        logic bits[$];
        int   g;
        for (int i = KB - 1; i >= 0; i--) bits.push_back(key[i]);
`ifdef KEY_LOADER_CHECKSUM_EN
        for (int i = 7; i >= 0; i--) bits.push_back(chk[i]);
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        exp_key = '0; exp_armed = 1'b0; exp_fault = 1'b0;
        check_all("load_entry", 1'b1);
        for (int i = 0; i < NB; i++) begin
            g = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int s = 0; s < g; s++) begin
                key_valid = 1'b0;
                key_bit   = 1'($urandom);
                start     = (mode == 2) && ($urandom_range(0, 3) == 0);
                step();
                start = 1'b0;
                check("stall.busy", busy, 1'b1);
                check("stall.key_out", key_out, 64'h0);
            end
            key_valid = 1'b1;
            key_bit   = bits[i];
            if (i == NB - 1) begin
                check("last_bit.busy", busy, 1'b1);
                check("last_bit.armed", key_armed, 1'b0);
            end
            step();
        end
        key_valid = 1'b0;
        model_load(key, chk);
        check_all("load_done", 1'b0);
    endtask

    initial begin
        logic [KB-1:0] k;
        logic [7:0]    c;
        model_reset();
        do_reset();
        check_all("reset", 1'b0);

        // Abort a load after 20 bits.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            key_valid = 1'b1; key_bit = 1'($urandom); step();
        end
        check("mid_load.busy", busy, 1'b1);
        rst = 1'b1; step(); step(); rst = 1'b0;
        check_all("mid_reset", 1'b0);
        key_valid = 1'b0;
        step();
        check_all("mid_reset_hold", 1'b0);

        run_load(64'h0123456789ABCDE0, 8'h0F, 0);
        run_load(64'h0123456789ABCDE0, 8'h0F, 1);
        run_load(64'hFFFFFFFFFFFFFFFF, 8'h00, 0);

`ifdef KEY_LOADER_CHECKSUM_EN
        run_load(64'h0123456789ABCDE0, 8'h0E, 0);
        step();
        check_all("fault_hold", 1'b0);
        run_load(64'h0123456789ABCDE0, 8'h0F, 2);
        for (int n = 0; n < MR; n++) run_load(64'h0123456789ABCDE0, 8'h0E, 0);
        check("lockout.flag", key_lockout, 1'b1);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'b1; key_bit = 1'($urandom); step();
        end
        key_valid = 1'b0;
        check_all("lockout_start", 1'b0);
        do_reset();
        check_all("lockout_reset", 1'b0);
`endif

        for (int n = 0; n < 8; n++) begin
            k = {$urandom, $urandom};
            c = ref_sum(k);
            if ((exp_retry < MR - 1) && ($urandom_range(0, 1) == 1)) c = c ^ 8'(1 + $urandom_range(0, 254));
            run_load(k, c, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_loader.md
# key_loader

Serial key provisioning unit that feeds the hardware-lock key bus. It fetches a KEY_BITS-wide unlock key from an external key source, typically a tamper-protected ROM or fuse shifter, one bit per handshake. It validates the key with an XOR byte checksum, then drives the assembled key to the per-stage lock keys (for example, the 4-bit PC-adder key slice). Until a valid key is armed, the key bus is all zeros, so every locked datapath stage sees a wrong key and corrupts its output.

## Interface
Parameters:
- KEY_BITS, 64, key width; multiple of 8.
- MAX_RETRY, 3, failed loads allowed before permanent lockout; range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle load request.
- key_valid  input  1  source presents a bit on key_bit.
- key_bit  input  1  serial key/checksum data, MSB-first.
- key_ready  output  1  loader accepts a bit this cycle.
- key_out  output  KEY_BITS  key bus to lock modules; all zeros unless armed.
- key_armed  output  1  valid key is driven on key_out.
- key_fault  output  1  last load failed its checksum.
- key_lockout  output  1  retry budget exhausted.
- busy  output  1  load in progress (SHIFT or CHK).

## Operation
- States: IDLE, SHIFT, CHK, ARMED, FAULT, LOCKOUT.
- A bit transfers on any cycle with key_valid && key_ready. key_ready is 1 only in SHIFT and CHK.
- IDLE: start moves the FSM to SHIFT. The shift register and bit counter clear.
- SHIFT: accepts KEY_BITS bits into the shift register. The first bit accepted lands in key_out[KEY_BITS-1]. After the KEY_BITS-th transfer, the FSM moves to CHK.
- CHK: accepts 8 checksum bits, MSB-first. The expected checksum is the XOR of all KEY_BITS/8 key bytes.
- On the 8th checksum transfer:
  - On a match, the FSM moves to ARMED. key_out loads the shift register and the retry count clears.
  - On a mismatch, the retry count increments. The FSM moves to FAULT, or to LOCKOUT if the new count equals MAX_RETRY.
- ARMED: key_out holds the key and key_armed=1. A start clears key_out to zero and key_armed to 0, then enters SHIFT (re-provisioning).
- FAULT: key_out=0 and key_fault=1. A start enters SHIFT and clears key_fault.
- LOCKOUT: key_out=0, key_fault=1, key_lockout=1. start is ignored; only rst exits.
- start while busy is ignored.
- key_valid without key_ready is ignored; no bit is consumed.
- Stalls: key_valid may drop for any number of cycles mid-load. The counters hold.
- The shift register never drives key_out directly. key_out changes only on entry to ARMED, on leaving ARMED, or on rst.

## Timing
- Reset values: state IDLE, key_out=0, key_armed=0, key_fault=0, key_lockout=0, busy=0, key_ready=0, retry count 0.
- rst mid-load aborts the load at the next edge with the same values.
- If start is sampled on edge N, key_ready=1 and busy=1 from cycle N+1.
- An uninterrupted load takes KEY_BITS+8 transfer cycles.
- key_armed, or key_fault, rises on the edge of the final checksum transfer. It is visible the next cycle. On that same edge, key_ready and busy fall.
- Minimum start-to-armed latency is 1+KEY_BITS+8 cycles (73 at default).
- On start in ARMED, key_out=0 and key_armed=0 from the next cycle.

## Configuration
- KEY_LOADER_CHECKSUM_EN defined: full CHK phase, retry counting, FAULT and LOCKOUT as above.
- Not defined:
  - CHK, FAULT and LOCKOUT are omitted, and key_fault and key_lockout are tied to 0.
  - After the KEY_BITS-th transfer, the FSM enters ARMED directly, so key_armed rises one edge after the last key bit.
  - MAX_RETRY is unused.

## Test plan
- Reset check: assert rst for 2 cycles mid-SHIFT, after 20 bits. Then key_ready=0, busy=0, key_out=0, all flags 0, and state is IDLE.
- Good load: start, then key 64'h0123456789ABCDE0 and checksum 8'h0F with key_valid held high. key_armed=1 exactly 73 cycles after start, and key_out=64'h0123456789ABCDE0.
- Stalled load: the same key with key_valid toggling 1/0 every cycle. The result is identical, with key_armed after 1+2×72 cycles. No bits are consumed while key_valid=0.
- Bad checksum: the same key with checksum 8'h0E. key_fault=1, key_out=0 and key_armed=0. A second start followed by the correct checksum arms the key and clears key_fault.
- Lockout: three consecutive bad-checksum loads give key_lockout=1. A fourth start keeps key_ready=0 and key_out=0; only rst recovers.
- Re-provision: in ARMED, pulse start. The next cycle shows key_out=0 and key_armed=0. Loading 64'hFFFFFFFFFFFFFFFF with checksum 8'h00 arms the new value.
